// File: rtl/pipe_prefix_addsub.sv
// Pipelined Kogge-Stone adder/subtractor (ADD/SUB/ADC/SBB) with valid/ready on both sides.
// Optional status flags (out_c/out_v/out_z/out_n) are built only when PPA_FLAGS_EN is defined.
module pipe_prefix_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n
);

    localparam int K = $clog2(WIDTH);

    // One beat as it moves through the tree: valid, carry-in, bitwise P (for the
    // final sum), and the running group generate/propagate.
    typedef struct packed {
        logic             v;
        logic             c;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
    } node_t;

    // Register boundary m sits after prefix level ceil(m*K/STAGES).
    function automatic bit is_bnd(input int lvl);
        for (int m = 1; m < STAGES; m++) begin
            if ((m * K + STAGES - 1) / STAGES == lvl) return 1'b1;
        end
        return 1'b0;
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] g0;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // op[0] selects inverted B; op[1] selects the external carry, else carry = op[0].
    assign b_eff   = in_op[0] ? ~in_b : in_b;
    assign cin_eff = in_op[1] ? in_cin : in_op[0];
    assign p0      = in_a ^ b_eff;
    // Folding cin into bit 0 makes prefix G[i:0] the carry into bit i+1 directly.
    assign g0      = (in_a & b_eff) | {{(WIDTH-1){1'b0}}, p0[0] & cin_eff};

    for (genvar j = 0; j <= K; j++) begin : g_lvl
        node_t l;
        node_t q;

        if (j == 0) begin : g_in
            assign l = {in_valid, cin_eff, p0, g0, p0};
        end else begin : g_pre
            localparam int D = 1 << (j - 1);
            localparam logic [WIDTH-1:0] LOW = {WIDTH{1'b1}} >> (WIDTH - D);
            node_t s;
            assign s = g_lvl[j-1].q;
            assign l = {s.v, s.c, s.x,
                        s.g | (s.p & (s.g << D)),
                        s.p & ((s.p << D) | LOW)};
        end

        if (is_bnd(j)) begin : g_reg
            // NOTE: the reset here is synchronous and clears data as well as valid,
            // so a reset never leaves stale operands behind a cleared valid bit.
            always_ff @(posedge clk) begin
                if (!rst_n)   q <= '0;
                else if (adv) q <= l;
            end
        end else begin : g_thru
            assign q = l;
        end
    end

    node_t            f;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d;
    logic             unused_bits;

    assign f     = g_lvl[K].q;
    assign carry = {f.g[WIDTH-2:0], f.c};
    assign sum_d = f.x ^ carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if (adv) begin
            out_valid <= f.v;
            out_sum   <= sum_d;
        end
    end

`ifdef PPA_FLAGS_EN
    // Overflow as carry-into-MSB xor carry-out, equivalent to the sign-compare form.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_c <= 1'b0;
            out_v <= 1'b0;
            out_z <= 1'b0;
            out_n <= 1'b0;
        end else if (adv) begin
            out_c <= f.g[WIDTH-1];
            out_v <= carry[WIDTH-1] ^ f.g[WIDTH-1];
            out_z <= ~|sum_d;
            out_n <= sum_d[WIDTH-1];
        end
    end
    assign unused_bits = ^f.p;
`else
    assign out_c       = 1'b0;
    assign out_v       = 1'b0;
    assign out_z       = 1'b0;
    assign out_n       = 1'b0;
    assign unused_bits = ^{f.p, f.g[WIDTH-1]};
`endif

endmodule

// File: tb/tb_pipe_prefix_addsub.sv
// Self-checking bench for pipe_prefix_addsub: directed vectors, backpressure, reset
// mid-stream and randomized traffic against an arithmetic reference model.
module tb_pipe_prefix_addsub;

    localparam int W = 32;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic [1:0]   in_op = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_c, out_v, out_z, out_n;

    always #5 clk = ~clk;

    pipe_prefix_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         c, v, z, n;
        int           cyc;
    } res_t;

    res_t exp_q[$];
    res_t obs;
    bit   popped;
    logic rdy_seen;
    logic ov_seen;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference: plain (W+1)-bit addition of A, effective B and effective carry.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci_in, input logic [1:0] op);
        logic [W-1:0] be;
        logic         ci;
        logic [W:0]   full;
        res_t         r;
        be   = op[0] ? ~b : b;
        ci   = op[1] ? ci_in : op[0];
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci};
        r.sum = full[W-1:0];
        r.cyc = 0;
`ifdef PPA_FLAGS_EN
        r.c = full[W];
        r.v = (a[W-1] == be[W-1]) && (r.sum[W-1] != a[W-1]);
        r.z = (r.sum == '0);
        r.n = r.sum[W-1];
`else
        r.c = 1'b0;
        r.v = 1'b0;
        r.z = 1'b0;
        r.n = 1'b0;
`endif
        return r;
    endfunction

    function automatic logic [W+3:0] flat(input res_t r);
        return {r.sum, r.c, r.v, r.z, r.n};
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [63:0] t;
        case ($urandom_range(0, 5))
            0:       t = '0;
            1:       t = '1;
            2:       t = 64'(1) << (W - 1);
            3:       t = (64'(1) << (W - 1)) - 64'(1);
            default: t = {$urandom(), $urandom()};
        endcase
        return t[W-1:0];
    endfunction

    // Drives one cycle from a negedge, records transfers seen before the next
    // rising edge, and returns at the following negedge.
    task automatic cycle(input bit iv, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic [1:0] op, input bit ordy);
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        in_cin    = ci;
        in_op     = op;
        out_ready = ordy;
        #1;
        rdy_seen = in_ready;
        ov_seen  = out_valid;
        if (in_valid && in_ready && rst_n) begin
            res_t r;
            r = model(a, b, ci, op);
            r.cyc = cyc;
            exp_q.push_back(r);
        end
        popped  = (out_valid && out_ready && rst_n) ? 1'b1 : 1'b0;
        obs.sum = out_sum;
        obs.c   = out_c;
        obs.v   = out_v;
        obs.z   = out_z;
        obs.n   = out_n;
        obs.cyc = cyc;
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle(1'b1, rnd_word(), rnd_word(), 1'b1, 2'b01, 1'b0);
        cycle(1'b1, rnd_word(), rnd_word(), 1'b1, 2'b10, 1'b1);
        rst_n = 1'b1;
        cycle(1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (ov_seen !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b exp 0", ov_seen);
        end
        checks++;
        if (rdy_seen !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b exp 1", rdy_seen);
        end
        checks++;
        if (flat(obs) !== '0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", flat(obs));
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] da [6] = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF,
                                  32'h0000_0005, 32'h0000_1234, 32'h7FFF_FFFF};
        logic [W-1:0] db [6] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000,
                                  32'h0000_0007, 32'h0000_1234, 32'h0000_0001};
        logic         dci [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [1:0]   dop [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
        logic [W-1:0] dsum [6] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0000,
                                    32'hFFFF_FFFE, 32'h0000_0000, 32'h8000_0000};
        logic [3:0]   dfl [6] = '{4'b1010, 4'b1100, 4'b1010, 4'b0001, 4'b1010, 4'b0101};
        logic [3:0]   want_fl;
        int got = 0;
        res_t e;
        for (int t = 0; t < 30 && got < 6; t++) begin
            if (t < 6) cycle(1'b1, da[t], db[t], dci[t], dop[t], 1'b1);
            else       cycle(1'b0, rnd_word(), rnd_word(), 1'b1, 2'b11, 1'b1);
            if (popped) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL directed_extra got %h exp none", obs.sum);
                end else begin
                    e = exp_q.pop_front();
                    if (flat(obs) !== flat(e)) begin
                        errors++; $display("FAIL directed_model[%0d] got %h exp %h", got, flat(obs), flat(e));
                    end
                    checks++;
                    if (obs.cyc != e.cyc + S) begin
                        errors++; $display("FAIL directed_latency[%0d] got %0d exp %0d", got, obs.cyc - e.cyc, S);
                    end
                end
`ifdef PPA_FLAGS_EN
                want_fl = dfl[got];
`else
                want_fl = 4'b0000;
`endif
                checks++;
                if ({obs.sum, obs.c, obs.v, obs.z, obs.n} !== {dsum[got], want_fl}) begin
                    errors++;
                    $display("FAIL directed_const[%0d] got %h/%b exp %h/%b", got, obs.sum,
                             {obs.c, obs.v, obs.z, obs.n}, dsum[got], want_fl);
                end
                got++;
            end
        end
        checks++;
        if (got != 6) begin
            errors++; $display("FAIL directed_count got %0d exp 6", got);
        end
    endtask

    task automatic test_backpressure();
        int bi = 0;
        int got = 0;
        logic [W-1:0] held = '0;
        bit ordy;
        bit iv;
        res_t e;
        for (int t = 0; t < 40 && got < 8; t++) begin
            ordy = !(t >= 4 && t <= 6);
            iv   = (bi < 8);
            cycle(iv, W'(bi), W'(bi), 1'b0, 2'b00, ordy);
            if (iv && rdy_seen === 1'b1) bi++;
            if (t >= 4 && t <= 6) begin
                checks++;
                if (rdy_seen !== 1'b0 || ov_seen !== 1'b1) begin
                    errors++; $display("FAIL bp_stall_ready t=%0d got rdy=%b ov=%b exp rdy=0 ov=1", t, rdy_seen, ov_seen);
                end
                if (t == 4) held = obs.sum;
                else begin
                    checks++;
                    if (obs.sum !== held) begin
                        errors++; $display("FAIL bp_stable t=%0d got %h exp %h", t, obs.sum, held);
                    end
                end
            end
            if (popped) begin
                checks++;
                if (obs.sum !== W'(2 * got)) begin
                    errors++; $display("FAIL bp_order[%0d] got %h exp %h", got, obs.sum, W'(2 * got));
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (flat(obs) !== flat(e)) begin
                        errors++; $display("FAIL bp_model[%0d] got %h exp %h", got, flat(obs), flat(e));
                    end
                end
                got++;
            end
        end
        checks++;
        if (got != 8) begin
            errors++; $display("FAIL bp_count got %0d exp 8", got);
        end
        for (int t = 0; t < 5; t++) begin
            cycle(1'b0, '0, '0, 1'b0, 2'b00, 1'b1);
            checks++;
            if (ov_seen !== 1'b0) begin
                errors++; $display("FAIL bp_duplicate got out_valid=%b exp 0", ov_seen);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit leaked = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, W'(100 + i), W'(7), 1'b0, 2'b00, 1'b0);
        rst_n = 1'b0;
        cycle(1'b0, '0, '0, 1'b0, 2'b00, 1'b0);
        exp_q.delete();
        rst_n = 1'b1;
        cycle(1'b0, '0, '0, 1'b0, 2'b00, 1'b1);
        checks++;
        if (ov_seen !== 1'b0 || flat(obs) !== '0) begin
            errors++; $display("FAIL midreset_clear got ov=%b out=%h exp ov=0 out=0", ov_seen, flat(obs));
        end
        checks++;
        if (rdy_seen !== 1'b1) begin
            errors++; $display("FAIL midreset_ready got %b exp 1", rdy_seen);
        end
        for (int t = 0; t < 8; t++) begin
            cycle(1'b0, '0, '0, 1'b0, 2'b00, 1'b1);
            if (ov_seen !== 1'b0) leaked = 1'b1;
        end
        checks++;
        if (leaked) begin
            errors++; $display("FAIL midreset_leak got out_valid=1 exp 0");
        end
    endtask

    task automatic test_random();
        res_t e;
        int   n = 0;
        for (int t = 0; t < 4000; t++) begin
            bit full_rate = (t < 1500);
            bit ordy = full_rate ? 1'b1 : ($urandom_range(0, 9) < 7);
            cycle($urandom_range(0, 3) != 0, rnd_word(), rnd_word(), 1'($urandom),
                  2'($urandom), ordy);
            if (full_rate) begin
                checks++;
                if (rdy_seen !== 1'b1) begin
                    errors++; $display("FAIL rand_ready t=%0d got %b exp 1", t, rdy_seen);
                end
            end
            if (popped) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra t=%0d got %h exp none", t, obs.sum);
                end else begin
                    e = exp_q.pop_front();
                    if (flat(obs) !== flat(e)) begin
                        errors++; $display("FAIL rand_model[%0d] got %h exp %h", n, flat(obs), flat(e));
                    end
                    if (full_rate) begin
                        checks++;
                        if (obs.cyc != e.cyc + S) begin
                            errors++; $display("FAIL rand_latency[%0d] got %0d exp %0d", n, obs.cyc - e.cyc, S);
                        end
                    end
                end
                n++;
            end
        end
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) begin
            cycle(1'b0, '0, '0, 1'b0, 2'b00, 1'b1);
            if (popped) begin
                e = exp_q.pop_front();
                checks++;
                if (flat(obs) !== flat(e)) begin
                    errors++; $display("FAIL rand_drain got %h exp %h", flat(obs), flat(e));
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rand_lost got %0d pending exp 0", exp_q.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_prefix_addsub.md
# pipe_prefix_addsub

Parametrised, pipelined Kogge-Stone prefix adder/subtractor with valid/ready handshaking on both sides and optional status flags. It generalises the combinational 32-bit prefix adder to any power-of-two width, adds subtract and carry/borrow-chain modes, and can be cut into 1 to log2(WIDTH)+1 register stages. It sits between operand-select and writeback in the ALU datapath, and it is the adder used when the ALU needs to run at the higher clock.

## Interface
- WIDTH, 32, operand width; power of two, 4..64
- STAGES, 2, register stages = latency in cycles; 1..log2(WIDTH)+1
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in; used only by ADC/SBB
- in_op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBB
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  WIDTH  result
- out_c  out  1  carry out of the MSB
- out_v  out  1  signed overflow
- out_z  out  1  out_sum == 0
- out_n  out  1  out_sum[WIDTH-1]

## Operation
- Effective B and carry-in are fixed by the op:
  - ADD: B, 0
  - SUB: ~B, 1
  - ADC: B, in_cin
  - SBB: ~B, in_cin, where in_cin = 1 means no borrow
- P = A ^ Beff and G = A & Beff. The prefix tree has k = log2(WIDTH) levels, with level j at distance 2^(j-1).
- Carry[i] = G[i-1:0] | (P[i-1:0] & cin), and Carry[0] = cin. Sum = P ^ Carry.
- out_c = G[W-1:0] | (P[W-1:0] & cin). The raw carry is reported for every op; it is not inverted for subtract.
- out_v = (A[msb] == Beff[msb]) & (Sum[msb] != A[msb]).
- Pipeline register boundaries:
  - Boundary m (m = 1..STAGES-1) sits after prefix level ceil(m*k/STAGES).
  - The final boundary is always the output register, which holds sum and flags.
  - cin, P and partial G/P travel with the data.
- Each stage carries a valid bit. The pipeline uses a global advance: adv = ~out_valid | out_ready.
  - When adv = 1, every stage shifts forward and stage 1 captures in_valid.
  - When adv = 0, all stages hold.
  - in_ready = adv, which is combinational from out_valid and out_ready.
- Bubbles are not collapsed during a stall. This is a documented throughput limitation.
- A beat transfers on the input when in_valid & in_ready, and on the output when out_valid & out_ready.
- Results leave in the same order they arrived. The block never drops or duplicates a result.

## Timing
- Reset (rst_n = 0 at an edge):
  - All valid bits clear.
  - All data and flag registers go to 0, so out_sum, out_c, out_v, out_z and out_n read 0.
  - in_ready = 1 in the cycle after reset, because out_valid = 0.
- Reset mid-operation discards every in-flight beat, and no partial result is presented.
- Latency: a beat accepted at edge t shows out_valid = 1 after edge t+STAGES-1, provided no stall intervenes. STAGES = 1 therefore means a single output register (one-cycle latency).
- Throughput is one beat per cycle while out_ready = 1.
- out_valid = 1 with out_ready = 0:
  - out_sum and the flags hold stable.
  - in_ready = 0, and in_valid is ignored.
- The consumer may assert out_ready with out_valid = 0. This has no effect beyond keeping adv = 1.
- On a simultaneous input accept and output pop, both transfers occur on the same edge.
- The producer's in_* signals may change freely while in_valid = 0.

## Configuration
- PPA_FLAGS_EN defined: the out_c, out_v, out_z and out_n logic and registers are built as described above.
- PPA_FLAGS_EN undefined: the flag ports remain, constantly 0, and no flag logic or registers are built. out_sum, the handshake and latency are unchanged.

## Test plan
- Reset then ADD, WIDTH = 32, STAGES = 2:
  - Stimulus: a = 0x0000_0001, b = 0xFFFF_FFFF, out_ready = 1.
  - Response: out_valid exactly 1 cycle after the accept edge, sum = 0, c = 1, z = 1, v = 0, n = 0.
- SUB overflow:
  - Stimulus: a = 0x8000_0000, b = 0x0000_0001.
  - Response: sum = 0x7FFF_FFFF, v = 1, c = 1, n = 0.
- 64-bit chain, ADC then SBB:
  - ADC with a = 0xFFFF_FFFF, b = 0, cin = 1 -> sum = 0, c = 1.
  - SBB with a = 5, b = 7, cin = 1 -> sum = 0xFFFF_FFFE, c = 0.
- Backpressure, STAGES = 3:
  - Stimulus: stream 8 back-to-back beats (a = i, b = i); out_ready low for cycles 4-6.
  - Response: in_ready low in the same cycles; outputs 0, 2, 4 … 14 in order, each exactly once; out_sum stable while stalled.
- Reset mid-stream:
  - Stimulus: rst_n = 0 for one edge with 3 beats in flight.
  - Response: out_valid = 0 and all outputs 0 on the next cycle; none of the 3 beats ever emerges.
- Sweep:
  - Stimulus: WIDTH ∈ {8, 32, 64} × STAGES ∈ {1, max}, 10k random ops, with and without PPA_FLAGS_EN.
  - Response: sum and flags match the reference model, with exact latency; flags are 0 when the macro is undefined.
